reg_hazard_ctrl: RTL and testbench
==================================

Name: reg_hazard_ctrl

Overview:
- Issue-side interlock and register-file write-port arbiter between the decoder and the integer register file.
- Keeps a per-register busy scoreboard for registers with writes in flight.
- Stalls decode on RAW/WAW hazards on rs1/rs2/rs3/rd.
- Arbitrates the single RF write port between the fixed-latency ALU pipe and the long-latency unit (mul/div).

Parameters:
- NREGS, 32, number of integer registers; x0 is hardwired zero.
- ADDR_W, 5, register address width; equals clog2(NREGS).
- MAX_LONG, 4, maximum long-latency ops in flight.
- STARVE_LIMIT, 8, consecutive denied long-unit writeback cycles before ALU issue is throttled.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rsn_i  in  1  reset, asynchronous, active-high.
- dec_valid_i  in  1  decoded instruction presented.
- dec_rs1_i / dec_rs2_i / dec_rs3_i  in  ADDR_W each  source register addresses.
- dec_use_rs1_i / dec_use_rs2_i / dec_use_rs3_i  in  1 each  source actually read.
- dec_rd_i  in  ADDR_W  destination register.
- dec_wen_i  in  1  instruction writes an integer register.
- dec_long_i  in  1  instruction goes to the long-latency unit.
- issue_ready_o  out  1  instruction may issue this cycle; issue = dec_valid_i & issue_ready_o.
- alu_wb_valid_i  in  1  ALU writeback request; cannot be back-pressured.
- alu_wb_addr_i  in  ADDR_W  ALU writeback register.
- lng_wb_valid_i  in  1  long-unit writeback request.
- lng_wb_addr_i  in  ADDR_W  long-unit writeback register.
- lng_wb_ready_o  out  1  long-unit writeback granted this cycle.
- rf_we_o  out  1  RF write enable.
- rf_waddr_o  out  ADDR_W  RF write address.
- rf_wsel_o  out  1  RF write data select: 0 = ALU, 1 = long unit.

Behaviour:
- Reset (async assert, held while rsn_i=1):
  - busy[NREGS-1:0]=0, long_cnt=0, starve_cnt=0, throttle=0.
  - Outputs: issue_ready_o=0, lng_wb_ready_o=0, rf_we_o=0, rf_waddr_o=0, rf_wsel_o=0.
  - Reset mid-operation discards all in-flight tracking; no writeback is granted while in reset.
- Hazard check, combinational, same cycle. Stall (issue_ready_o=0) if any of:
  - a used source has busy[rsN]=1;
  - dec_wen_i & busy[rd]=1 (WAW);
  - dec_long_i & long_cnt==MAX_LONG;
  - throttle=1 & dec_long_i=0 & dec_wen_i=1.
  - x0 is never busy. Busy state is the registered value; a register cleared by writeback in cycle N is issuable in cycle N+1 (no same-cycle bypass).
- On issue with dec_wen_i & rd!=0:
  - set busy[rd] next cycle;
  - if dec_long_i, long_cnt+1.
- Write-port arbitration (combinational):
  - ALU has absolute priority: alu_wb_valid_i → rf_we_o=1, rf_waddr_o=alu_wb_addr_i, rf_wsel_o=0, lng_wb_ready_o=0.
  - Else lng_wb_valid_i → lng_wb_ready_o=1, rf_we_o=1, rf_waddr_o=lng_wb_addr_i, rf_wsel_o=1.
  - Else rf_we_o=0; rf_waddr_o and rf_wsel_o keep the last granted value, registered.
  - A writeback addressed to x0 is granted (lng_wb_ready_o follows the rules above) but forces rf_we_o=0.
- On a granted writeback, clear busy[waddr] next cycle. Clearing a non-busy register is a no-op.
- Issue-set and writeback-clear on the same register in one cycle is impossible: issue is blocked while busy.
- long_cnt:
  - decrements on a long grant;
  - simultaneous long issue and long grant leave it unchanged;
  - saturates at 0 and MAX_LONG, never wraps.
- Starvation:
  - starve_cnt increments each cycle lng_wb_valid_i=1 and the grant is denied; it resets to 0 on a grant or when lng_wb_valid_i=0.
  - When starve_cnt reaches STARVE_LIMIT, throttle←1 and remains set until the next long grant, then throttle←0 the following cycle.
  - Throttle blocks only new ALU-writing instructions, so the ALU pipe drains and the long unit is guaranteed a grant.

Decomposition:
- Shared package contents:
  - NREGS and ADDR_W;
  - the x0 address constant;
  - the rf_wsel encodings WSEL_ALU=0 and WSEL_LONG=1.
- Sub-module wb_arbiter: the fixed-priority grant, the starve_cnt/throttle logic, and the registered last-address hold.
- Top level keeps the scoreboard, long_cnt and the hazard check.

Test Plan:
- Reset mid-operation: busy[5]=1 and long_cnt=2, assert rsn_i for 1 cycle → all busy=0, long_cnt=0, issue_ready_o=0 during reset; after release a long op to rd=5 issues immediately.
- RAW: issue long op rd=7; next cycle present rs1=7 with use_rs1=1 → issue_ready_o=0. Grant long writeback to 7 in cycle N → ready=0 in N, ready=1 in N+1. With use_rs1=0 and rs1=7 → no stall.
- WAW and x0: with busy[3]=1, present dec_wen=1 rd=3 → stall. Issue to rd=0 → busy unchanged. ALU writeback to 0 → rf_we_o=0.
- Arbitration collision: alu_wb_valid_i=1 addr 4 and lng_wb_valid_i=1 addr 9 in the same cycle → rf_waddr_o=4, rf_wsel_o=0, lng_wb_ready_o=0. Next cycle without ALU → rf_waddr_o=9, rf_wsel_o=1, lng_wb_ready_o=1.
- Long-op limit: issue 4 long ops to rd=1..4 → 5th long op stalls. Long grant and new long issue in the same cycle → long_cnt stays 4.
- Starvation: hold ALU writeback valid every cycle and lng_wb_valid_i=1 for 8 cycles → throttle=1, ALU-writing issue stalls while long issue and non-writing issue proceed. Drop ALU writeback → long granted, throttle clears the next cycle.

Source files
------------

// File: rtl/reg_hazard_ctrl_pkg.sv
// Shared constants and types for the issue interlock / RF write-port arbiter.
package reg_hazard_ctrl_pkg;

   localparam int NREGS  = 32;
   localparam int ADDR_W = $clog2(NREGS);

   typedef logic [ADDR_W-1:0] reg_addr_t;

   localparam reg_addr_t X0_ADDR   = '0;
   localparam logic      WSEL_ALU  = 1'b0;
   localparam logic      WSEL_LONG = 1'b1;

endpackage : reg_hazard_ctrl_pkg

// File: rtl/reg_hazard_ctrl_if.sv
// Decoder, writeback and RF write-port signals between the pipeline and reg_hazard_ctrl.
interface reg_hazard_ctrl_if;
   import reg_hazard_ctrl_pkg::*;

   logic      dec_valid_i;
   reg_addr_t dec_rs1_i;
   reg_addr_t dec_rs2_i;
   reg_addr_t dec_rs3_i;
   logic      dec_use_rs1_i;
   logic      dec_use_rs2_i;
   logic      dec_use_rs3_i;
   reg_addr_t dec_rd_i;
   logic      dec_wen_i;
   logic      dec_long_i;
   logic      issue_ready_o;

   logic      alu_wb_valid_i;
   reg_addr_t alu_wb_addr_i;
   logic      lng_wb_valid_i;
   reg_addr_t lng_wb_addr_i;
   logic      lng_wb_ready_o;

   logic      rf_we_o;
   reg_addr_t rf_waddr_o;
   logic      rf_wsel_o;

   modport master (
      output dec_valid_i, dec_rs1_i, dec_rs2_i, dec_rs3_i,
             dec_use_rs1_i, dec_use_rs2_i, dec_use_rs3_i,
             dec_rd_i, dec_wen_i, dec_long_i,
             alu_wb_valid_i, alu_wb_addr_i, lng_wb_valid_i, lng_wb_addr_i,
      input  issue_ready_o, lng_wb_ready_o, rf_we_o, rf_waddr_o, rf_wsel_o
   );

   modport slave (
      input  dec_valid_i, dec_rs1_i, dec_rs2_i, dec_rs3_i,
             dec_use_rs1_i, dec_use_rs2_i, dec_use_rs3_i,
             dec_rd_i, dec_wen_i, dec_long_i,
             alu_wb_valid_i, alu_wb_addr_i, lng_wb_valid_i, lng_wb_addr_i,
      output issue_ready_o, lng_wb_ready_o, rf_we_o, rf_waddr_o, rf_wsel_o
   );

endinterface : reg_hazard_ctrl_if

// File: rtl/reg_hazard_ctrl_wb_arbiter.sv
// Fixed-priority RF write-port arbiter (ALU over long unit) with long-unit starvation throttle.
module wb_arbiter
   import reg_hazard_ctrl_pkg::*;
#(
   parameter int STARVE_LIMIT = 8
) (
   input  logic      clk_i,
   input  logic      rsn_i,
   input  logic      alu_wb_valid_i,
   input  reg_addr_t alu_wb_addr_i,
   input  logic      lng_wb_valid_i,
   input  reg_addr_t lng_wb_addr_i,
   output logic      lng_wb_ready_o,
   output logic      rf_we_o,
   output reg_addr_t rf_waddr_o,
   output logic      rf_wsel_o,
   output logic      throttle_o
);

   localparam int          SW      = $clog2(STARVE_LIMIT + 1);
   localparam logic [SW-1:0] LIMIT_C = SW'(STARVE_LIMIT);

   logic          alu_grant;
   logic          lng_grant;
   reg_addr_t     waddr_d, waddr_q;
   logic          wsel_d, wsel_q;
   logic [SW-1:0] starve_d, starve_q;
   logic          throttle_d, throttle_q;

   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can infer a latch.
      alu_grant  = alu_wb_valid_i & ~rsn_i;
      lng_grant  = lng_wb_valid_i & ~alu_wb_valid_i & ~rsn_i;
      waddr_d    = waddr_q;
      wsel_d     = wsel_q;
      starve_d   = '0;
      throttle_d = throttle_q;

      if (alu_grant) begin
         waddr_d = alu_wb_addr_i;
         wsel_d  = WSEL_ALU;
      end else if (lng_grant) begin
         waddr_d = lng_wb_addr_i;
         wsel_d  = WSEL_LONG;
      end

      // Saturate rather than wrap so a very long denial keeps the throttle asserted.
      if (lng_wb_valid_i && alu_wb_valid_i)
         starve_d = (starve_q == LIMIT_C) ? starve_q : starve_q + SW'(1);

      if (lng_grant)
         throttle_d = 1'b0;
      else if (starve_d == LIMIT_C)
         throttle_d = 1'b1;
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk_i or posedge rsn_i) begin
      if (rsn_i) begin
         waddr_q    <= X0_ADDR;
         wsel_q     <= WSEL_ALU;
         starve_q   <= '0;
         throttle_q <= 1'b0;
      end else begin
         waddr_q    <= waddr_d;
         wsel_q     <= wsel_d;
         starve_q   <= starve_d;
         throttle_q <= throttle_d;
      end
   end

   // A granted write to x0 still consumes the port but never writes the file.
   assign rf_we_o        = (alu_grant | lng_grant) & (waddr_d != X0_ADDR);
   assign rf_waddr_o     = waddr_d;
   assign rf_wsel_o      = wsel_d;
   assign lng_wb_ready_o = lng_grant;
   assign throttle_o     = throttle_q;

endmodule : wb_arbiter

// File: rtl/reg_hazard_ctrl.sv
// Issue interlock: busy scoreboard, long-op occupancy and hazard stall, plus the RF write-port arbiter.
module reg_hazard_ctrl
   import reg_hazard_ctrl_pkg::*;
#(
   parameter int MAX_LONG     = 4,
   parameter int STARVE_LIMIT = 8
) (
   input  logic             clk_i,
   input  logic             rsn_i,
   reg_hazard_ctrl_if.slave bus
);

   localparam int             LCW       = $clog2(MAX_LONG + 1);
   localparam logic [LCW-1:0] MAX_C     = LCW'(MAX_LONG);

   logic [NREGS-1:0] busy_d, busy_q;
   logic [LCW-1:0]   long_cnt_d, long_cnt_q;

   logic      stall;
   logic      issue_ready;
   logic      set_busy;
   logic      long_inc;
   logic      long_dec;
   logic      throttle;
   logic      lng_ready;
   logic      rf_we;
   reg_addr_t rf_waddr;
   logic      rf_wsel;

   wb_arbiter #(
      .STARVE_LIMIT (STARVE_LIMIT)
   ) u_wb_arbiter (
      .clk_i          (clk_i),
      .rsn_i          (rsn_i),
      .alu_wb_valid_i (bus.alu_wb_valid_i),
      .alu_wb_addr_i  (bus.alu_wb_addr_i),
      .lng_wb_valid_i (bus.lng_wb_valid_i),
      .lng_wb_addr_i  (bus.lng_wb_addr_i),
      .lng_wb_ready_o (lng_ready),
      .rf_we_o        (rf_we),
      .rf_waddr_o     (rf_waddr),
      .rf_wsel_o      (rf_wsel),
      .throttle_o     (throttle)
   );

   // Hazards look only at registered busy bits: a writeback clear is visible one cycle later.
   assign stall = (bus.dec_use_rs1_i & busy_q[bus.dec_rs1_i])
                | (bus.dec_use_rs2_i & busy_q[bus.dec_rs2_i])
                | (bus.dec_use_rs3_i & busy_q[bus.dec_rs3_i])
                | (bus.dec_wen_i     & busy_q[bus.dec_rd_i])
                | (bus.dec_long_i    & (long_cnt_q == MAX_C))
                | (throttle & ~bus.dec_long_i & bus.dec_wen_i);

   assign issue_ready = ~rsn_i & ~stall;
   assign set_busy    = bus.dec_valid_i & issue_ready & bus.dec_wen_i & (bus.dec_rd_i != X0_ADDR);
   assign long_inc    = set_busy & bus.dec_long_i;
   assign long_dec    = lng_ready;

   always_comb begin
      busy_d     = busy_q;
      long_cnt_d = long_cnt_q;

      // rf_we is already suppressed for x0, so it doubles as the clear strobe.
      if (rf_we)
         busy_d[rf_waddr] = 1'b0;
      if (set_busy)
         busy_d[bus.dec_rd_i] = 1'b1;
      busy_d[X0_ADDR] = 1'b0;

      if (long_inc && !long_dec && long_cnt_q != MAX_C)
         long_cnt_d = long_cnt_q + LCW'(1);
      else if (long_dec && !long_inc && long_cnt_q != '0)
         long_cnt_d = long_cnt_q - LCW'(1);
   end

   always_ff @(posedge clk_i or posedge rsn_i) begin
      if (rsn_i) begin
         busy_q     <= '0;
         long_cnt_q <= '0;
      end else begin
         busy_q     <= busy_d;
         long_cnt_q <= long_cnt_d;
      end
   end

   assign bus.issue_ready_o  = issue_ready;
   assign bus.lng_wb_ready_o = lng_ready;
   assign bus.rf_we_o        = rf_we;
   assign bus.rf_waddr_o     = rf_waddr;
   assign bus.rf_wsel_o      = rf_wsel;

endmodule : reg_hazard_ctrl

// File: tb/tb_reg_hazard_ctrl.sv
// Directed self-checking bench for reg_hazard_ctrl with hand-computed expectations.
module tb_reg_hazard_ctrl;

   logic clk;
   logic rsn;
   int   errors = 0;
   int   checks = 0;

   reg_hazard_ctrl_if bus ();

   reg_hazard_ctrl dut (
      .clk_i (clk),
      .rsn_i (rsn),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic dec(input logic v, input logic [4:0] rd, input logic wen, input logic lng);
      bus.dec_valid_i   = v;
      bus.dec_rd_i      = rd;
      bus.dec_wen_i     = wen;
      bus.dec_long_i    = lng;
      bus.dec_rs1_i     = 5'd0;
      bus.dec_rs2_i     = 5'd0;
      bus.dec_rs3_i     = 5'd0;
      bus.dec_use_rs1_i = 1'b0;
      bus.dec_use_rs2_i = 1'b0;
      bus.dec_use_rs3_i = 1'b0;
   endtask

   task automatic wb(input logic av, input logic [4:0] aa, input logic lv, input logic [4:0] la);
      bus.alu_wb_valid_i = av;
      bus.alu_wb_addr_i  = aa;
      bus.lng_wb_valid_i = lv;
      bus.lng_wb_addr_i  = la;
   endtask

   initial begin
      rsn = 1'b1;
      dec(1'b1, 5'd2, 1'b1, 1'b0);
      wb(1'b1, 5'd6, 1'b1, 5'd7);
      settle();
      check("rst_issue_ready", bus.issue_ready_o, 1'b0);
      check("rst_lng_ready", bus.lng_wb_ready_o, 1'b0);
      check("rst_rf_we", bus.rf_we_o, 1'b0);
      check("rst_rf_waddr", bus.rf_waddr_o, 5'd0);
      check("rst_rf_wsel", bus.rf_wsel_o, 1'b0);
      tick();
      tick();
      dec(1'b0, 5'd0, 1'b0, 1'b0);
      wb(1'b0, 5'd0, 1'b0, 5'd0);
      rsn = 1'b0;
      settle();

      // Reset mid-operation: busy[5], busy[6], long_cnt=2 then reset.
      dec(1'b1, 5'd5, 1'b1, 1'b1);
      settle();
      check("mid_issue5", bus.issue_ready_o, 1'b1);
      tick();
      dec(1'b1, 5'd6, 1'b1, 1'b1);
      settle();
      check("mid_issue6", bus.issue_ready_o, 1'b1);
      tick();
      dec(1'b0, 5'd9, 1'b0, 1'b0);
      bus.dec_rs1_i = 5'd5; bus.dec_use_rs1_i = 1'b1;
      settle();
      check("mid_raw5", bus.issue_ready_o, 1'b0);
      rsn = 1'b1;
      settle();
      check("mid_rst_ready", bus.issue_ready_o, 1'b0);
      tick();
      rsn = 1'b0;
      dec(1'b1, 5'd5, 1'b1, 1'b1);
      bus.dec_rs1_i = 5'd6; bus.dec_use_rs1_i = 1'b1;
      settle();
      check("post_rst_issue5", bus.issue_ready_o, 1'b1);
      tick();
      dec(1'b0, 5'd0, 1'b0, 1'b0);
      wb(1'b0, 5'd0, 1'b1, 5'd5);
      settle();
      check("wb5_lng_ready", bus.lng_wb_ready_o, 1'b1);
      check("wb5_rf_we", bus.rf_we_o, 1'b1);
      check("wb5_rf_waddr", bus.rf_waddr_o, 5'd5);
      check("wb5_rf_wsel", bus.rf_wsel_o, 1'b1);
      tick();
      wb(1'b0, 5'd0, 1'b0, 5'd0);

      // RAW on rd=7.
      dec(1'b1, 5'd7, 1'b1, 1'b1);
      settle();
      tick();
      dec(1'b0, 5'd0, 1'b0, 1'b0);
      bus.dec_rs1_i = 5'd7; bus.dec_use_rs1_i = 1'b0;
      settle();
      check("raw_unused_rs1", bus.issue_ready_o, 1'b1);
      bus.dec_rs3_i = 5'd7; bus.dec_use_rs3_i = 1'b1;
      settle();
      check("raw_rs3", bus.issue_ready_o, 1'b0);
      bus.dec_use_rs3_i = 1'b0;
      bus.dec_rs2_i = 5'd7; bus.dec_use_rs2_i = 1'b1;
      settle();
      check("raw_rs2", bus.issue_ready_o, 1'b0);
      bus.dec_use_rs2_i = 1'b0;
      bus.dec_use_rs1_i = 1'b1;
      wb(1'b0, 5'd0, 1'b1, 5'd7);
      settle();
      check("raw_rs1_grant_cycle", bus.issue_ready_o, 1'b0);
      tick();
      wb(1'b0, 5'd0, 1'b0, 5'd0);
      settle();
      check("raw_rs1_next_cycle", bus.issue_ready_o, 1'b1);

      // WAW and x0.
      dec(1'b1, 5'd3, 1'b1, 1'b0);
      settle();
      check("waw_issue3", bus.issue_ready_o, 1'b1);
      tick();
      dec(1'b0, 5'd3, 1'b1, 1'b0);
      settle();
      check("waw_stall3", bus.issue_ready_o, 1'b0);
      dec(1'b0, 5'd3, 1'b0, 1'b0);
      settle();
      check("waw_nowen3", bus.issue_ready_o, 1'b1);
      dec(1'b1, 5'd0, 1'b1, 1'b0);
      settle();
      check("x0_issue", bus.issue_ready_o, 1'b1);
      tick();
      dec(1'b0, 5'd0, 1'b1, 1'b0);
      bus.dec_use_rs1_i = 1'b1;
      wb(1'b1, 5'd0, 1'b0, 5'd0);
      settle();
      check("x0_not_busy", bus.issue_ready_o, 1'b1);
      check("x0_wb_rf_we", bus.rf_we_o, 1'b0);
      check("x0_wb_wsel", bus.rf_wsel_o, 1'b0);
      tick();
      dec(1'b0, 5'd0, 1'b0, 1'b0);
      wb(1'b1, 5'd3, 1'b0, 5'd0);
      settle();
      check("alu_wb3_we", bus.rf_we_o, 1'b1);
      check("alu_wb3_addr", bus.rf_waddr_o, 5'd3);
      tick();
      wb(1'b0, 5'd0, 1'b0, 5'd0);
      dec(1'b0, 5'd3, 1'b1, 1'b0);
      settle();
      check("hold3_we", bus.rf_we_o, 1'b0);
      check("hold3_addr", bus.rf_waddr_o, 5'd3);
      check("waw_cleared3", bus.issue_ready_o, 1'b1);

      // Arbitration collision.
      dec(1'b0, 5'd0, 1'b0, 1'b0);
      wb(1'b1, 5'd4, 1'b1, 5'd9);
      settle();
      check("col_addr", bus.rf_waddr_o, 5'd4);
      check("col_wsel", bus.rf_wsel_o, 1'b0);
      check("col_lng_ready", bus.lng_wb_ready_o, 1'b0);
      tick();
      wb(1'b0, 5'd0, 1'b1, 5'd9);
      settle();
      check("col2_addr", bus.rf_waddr_o, 5'd9);
      check("col2_wsel", bus.rf_wsel_o, 1'b1);
      check("col2_lng_ready", bus.lng_wb_ready_o, 1'b1);
      tick();
      wb(1'b0, 5'd0, 1'b0, 5'd0);
      settle();
      check("col_hold_addr", bus.rf_waddr_o, 5'd9);
      check("col_hold_wsel", bus.rf_wsel_o, 1'b1);

      // Long-op limit (long_cnt is 0 here; the stray grant above saturated it).
      for (int r = 1; r <= 4; r++) begin
         dec(1'b1, 5'(r), 1'b1, 1'b1);
         settle();
         check($sformatf("long_issue%0d", r), bus.issue_ready_o, 1'b1);
         tick();
      end
      dec(1'b0, 5'd8, 1'b1, 1'b1);
      settle();
      check("long_full_stall", bus.issue_ready_o, 1'b0);
      dec(1'b0, 5'd8, 1'b1, 1'b0);
      settle();
      check("long_full_alu_ok", bus.issue_ready_o, 1'b1);
      dec(1'b0, 5'd0, 1'b0, 1'b0);
      wb(1'b0, 5'd0, 1'b1, 5'd1);
      tick();
      dec(1'b1, 5'd1, 1'b1, 1'b1);
      wb(1'b0, 5'd0, 1'b1, 5'd2);
      settle();
      check("long_simul_issue", bus.issue_ready_o, 1'b1);
      check("long_simul_grant", bus.lng_wb_ready_o, 1'b1);
      tick();
      wb(1'b0, 5'd0, 1'b0, 5'd0);
      dec(1'b1, 5'd2, 1'b1, 1'b1);
      settle();
      check("long_cnt3_issue", bus.issue_ready_o, 1'b1);
      tick();
      dec(1'b0, 5'd12, 1'b1, 1'b1);
      settle();
      check("long_cnt4_stall", bus.issue_ready_o, 1'b0);
      dec(1'b0, 5'd0, 1'b0, 1'b0);
      for (int r = 1; r <= 4; r++) begin
         wb(1'b0, 5'd0, 1'b1, 5'(r));
         tick();
      end
      wb(1'b0, 5'd0, 1'b0, 5'd0);
      dec(1'b0, 5'd12, 1'b1, 1'b1);
      settle();
      check("long_drained", bus.issue_ready_o, 1'b1);

      // Starvation and throttle.
      wb(1'b1, 5'd20, 1'b1, 5'd21);
      dec(1'b0, 5'd13, 1'b1, 1'b0);
      for (int c = 1; c <= 7; c++) tick();
      settle();
      check("starve7_alu_ok", bus.issue_ready_o, 1'b1);
      tick();
      dec(1'b0, 5'd13, 1'b1, 1'b0);
      settle();
      check("thr_alu_stall", bus.issue_ready_o, 1'b0);
      check("thr_lng_denied", bus.lng_wb_ready_o, 1'b0);
      dec(1'b0, 5'd13, 1'b1, 1'b1);
      settle();
      check("thr_long_ok", bus.issue_ready_o, 1'b1);
      dec(1'b0, 5'd13, 1'b0, 1'b0);
      settle();
      check("thr_nowrite_ok", bus.issue_ready_o, 1'b1);
      tick();
      dec(1'b0, 5'd13, 1'b1, 1'b0);
      settle();
      check("thr_still_set", bus.issue_ready_o, 1'b0);
      wb(1'b0, 5'd0, 1'b1, 5'd21);
      settle();
      check("thr_grant", bus.lng_wb_ready_o, 1'b1);
      check("thr_grant_addr", bus.rf_waddr_o, 5'd21);
      check("thr_grant_cycle_stall", bus.issue_ready_o, 1'b0);
      tick();
      wb(1'b0, 5'd0, 1'b0, 5'd0);
      settle();
      check("thr_cleared", bus.issue_ready_o, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_reg_hazard_ctrl
